vga_timing_gen: RTL
===================

Name: vga_timing_gen

Overview:
Parametrised successor to the fixed sync generator and clock-divider pair in the GPU top level.
- Generates the pixel-clock enable, cycle/scanline counters, HS/VS/blank, frame strobe, frame counter and a line-compare interrupt.
- Geometry, sync polarity and divide ratio are set at elaboration time.
- Sits between the 100 MHz clock and pixel_generator, and drives the GPU irq output.

Parameters:
CLK_DIV, 2, system clocks per pixel (>=1)
H_VISIBLE, 640, visible pixels per line
H_FRONT, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync width (pixels)
H_BACK, 48, horizontal back porch (pixels)
V_VISIBLE, 480, visible lines
V_FRONT, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BACK, 33, vertical back porch (lines)
HS_POL, 0, active level of vga_hs
VS_POL, 0, active level of vga_vs
CYCLE_W, 10, cycle counter width; must hold H_TOTAL-1
LINE_W, 10, scanline counter width; must hold V_TOTAL-1

Ports:
CLK100MHz  input  1  system clock; all logic on rising edge
rst  input  1  synchronous, active-high reset
enable  input  1  1 = timing runs, 0 = freeze
irq_line  input  LINE_W  scanline that raises irq
irq_line_en  input  1  line-compare interrupt enable
irq_ack  input  1  one-cycle clear of irq
pixel_clk  output  1  one-CLK-wide pixel tick
cycle  output  CYCLE_W  horizontal position
scanline  output  LINE_W  vertical position
vga_hs  output  1  horizontal sync
vga_vs  output  1  vertical sync
vga_blank  output  1  1 outside visible area
frame_start  output  1  one-CLK pulse on wrap to (0,0)
frame_count  output  8  frames completed, modulo 256
irq  output  1  sticky line interrupt

Behaviour:
- Totals: H_TOTAL = sum of H_* parameters (800 at defaults); V_TOTAL = sum of V_* parameters (525 at defaults).
- Divider: div_cnt counts 0..CLK_DIV-1 while enable=1. Tick occurs on the clock where div_cnt==CLK_DIV-1; div_cnt then returns to 0. With CLK_DIV=1, a tick occurs every clock.
- pixel_clk is registered: high for exactly the one CLK cycle after the tick edge.
- On tick:
  - cycle increments; at H_TOTAL-1 it wraps to 0 and scanline increments.
  - scanline wraps from V_TOTAL-1 to 0.
- vga_hs, vga_vs and vga_blank are registered from next-state counters, so they always match the cycle/scanline values presented in the same clock. No extra latency.
- HS is active when H_VISIBLE+H_FRONT <= cycle < H_VISIBLE+H_FRONT+H_SYNC.
- VS is active when V_VISIBLE+V_FRONT <= scanline < V_VISIBLE+V_FRONT+V_SYNC.
- vga_blank = (cycle >= H_VISIBLE) | (scanline >= V_VISIBLE).
- frame_start pulses for one CLK when a tick moves the counters to (0,0). frame_count increments on that same edge and wraps 255->0.
- irq is set on a tick that moves the counters to (cycle 0, scanline==irq_line) when irq_line_en=1.
  - irq is held until irq_ack=1.
  - If set and ack occur on the same clock, set wins.
  - irq_line >= V_TOTAL never fires.
  - irq_line_en=0 blocks new sets but does not clear a pending irq.
- enable=0: div_cnt and counters hold; pixel_clk, frame_start = 0; other outputs hold. Resuming continues from the held div_cnt.
- Reset (any time, including mid-line or mid-frame), next clock:
  - div_cnt, cycle, scanline, frame_count = 0
  - pixel_clk, frame_start, irq = 0
  - vga_hs = ~HS_POL, vga_vs = ~VS_POL, vga_blank = 0
  - rst has priority over enable and irq_ack.

Optional Feature:
VGA_LINE_IRQ_EN
- Defined: line-compare interrupt logic as above.
- Undefined: irq tied to 0; irq_line, irq_line_en and irq_ack are ignored; no compare or sticky-flag logic is synthesised. Port list is unchanged.

Test Plan:
- Reset, defaults, enable=1: pixel_clk high every 2nd CLK; cycle reaches 799 then 0; scanline increments to 1 on that tick. After rst, vga_blank=0, vga_hs=1, vga_vs=1.
- Sweep one full line at defaults: vga_hs=0 exactly for cycle 656..751 (96 ticks); vga_blank=1 for cycle 640..799.
- Full frame at defaults:
  - vga_vs=0 for scanline 490..491.
  - frame_start pulses once after 840000 CLKs; frame_count=1.
  - 256 frames give frame_count=0.
- Line IRQ: irq_line=100, irq_line_en=1 (macro defined) → irq rises on tick to (0,100) and stays high. irq_ack on the same clock as a set leaves irq=1. With irq_line=600, irq never fires.
- enable=0 for 50 clocks at (cycle 123, line 45): counters frozen, no pixel_clk. Re-enable resumes at cycle 124.
- rst asserted mid-frame at (cycle 400, line 300) with irq=1: next clock all outputs are at reset values. Repeat with CLK_DIV=1 and CLK_DIV=4: tick period is 1 and 4 CLKs respectively.

Source files
------------

// File: rtl/vga_timing_gen.sv
// VGA timing generator: pixel-clock enable, cycle/scanline counters, syncs, blank and frame strobe.
// Optional line-compare interrupt is built only when VGA_LINE_IRQ_EN is defined.
module vga_timing_gen #(
   parameter int unsigned CLK_DIV   = 2,
   parameter int unsigned H_VISIBLE = 640,
   parameter int unsigned H_FRONT   = 16,
   parameter int unsigned H_SYNC    = 96,
   parameter int unsigned H_BACK    = 48,
   parameter int unsigned V_VISIBLE = 480,
   parameter int unsigned V_FRONT   = 10,
   parameter int unsigned V_SYNC    = 2,
   parameter int unsigned V_BACK    = 33,
   parameter bit          HS_POL    = 1'b0,
   parameter bit          VS_POL    = 1'b0,
   parameter int unsigned CYCLE_W   = 10,
   parameter int unsigned LINE_W    = 10
) (
   input  logic               CLK100MHz,
   input  logic               rst,
   input  logic               enable,
   input  logic [LINE_W-1:0]  irq_line,
   input  logic               irq_line_en,
   input  logic               irq_ack,
   output logic               pixel_clk,
   output logic [CYCLE_W-1:0] cycle,
   output logic [LINE_W-1:0]  scanline,
   output logic               vga_hs,
   output logic               vga_vs,
   output logic               vga_blank,
   output logic               frame_start,
   output logic [7:0]         frame_count,
   output logic               irq
);

   localparam int unsigned H_TOTAL  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
   localparam int unsigned V_TOTAL  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
   localparam int unsigned HS_START = H_VISIBLE + H_FRONT;
   localparam int unsigned HS_END   = HS_START + H_SYNC;
   localparam int unsigned VS_START = V_VISIBLE + V_FRONT;
   localparam int unsigned VS_END   = VS_START + V_SYNC;
   localparam int unsigned DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

   logic [DIV_W-1:0]   div_cnt_q, div_cnt_d;
   logic [CYCLE_W-1:0] cycle_q, cycle_d;
   logic [LINE_W-1:0]  scanline_q, scanline_d;
   logic [7:0]         frame_count_q, frame_count_d;
   logic               pixel_clk_q, frame_start_q;
   logic               hs_q, hs_d, vs_q, vs_d, blank_q, blank_d;
   logic               tick, wrap;

   always_comb begin
      tick          = enable && (div_cnt_q == DIV_LAST);
      div_cnt_d     = div_cnt_q;
      cycle_d       = cycle_q;
      scanline_d    = scanline_q;
      frame_count_d = frame_count_q;
      hs_d          = ~HS_POL;
      vs_d          = ~VS_POL;

      if (enable) begin
         div_cnt_d = tick ? '0 : div_cnt_q + DIV_W'(1);
      end

      if (tick) begin
         if (32'(cycle_q) == H_TOTAL - 1) begin
            cycle_d = '0;
            if (32'(scanline_q) == V_TOTAL - 1) begin
               scanline_d = '0;
            end else begin
               scanline_d = scanline_q + LINE_W'(1);
            end
         end else begin
            cycle_d = cycle_q + CYCLE_W'(1);
         end
      end

      wrap = tick && (cycle_d == '0) && (scanline_d == '0);
      if (wrap) begin
         frame_count_d = frame_count_q + 8'd1;
      end

      // Decode from next-state counters so syncs line up with the counters they accompany.
      if ((32'(cycle_d) >= HS_START) && (32'(cycle_d) < HS_END)) begin
         hs_d = HS_POL;
      end
      if ((32'(scanline_d) >= VS_START) && (32'(scanline_d) < VS_END)) begin
         vs_d = VS_POL;
      end
      blank_d = (32'(cycle_d) >= H_VISIBLE) || (32'(scanline_d) >= V_VISIBLE);
   end

   always_ff @(posedge CLK100MHz) begin
      if (rst) begin
         div_cnt_q     <= '0;
         cycle_q       <= '0;
         scanline_q    <= '0;
         frame_count_q <= '0;
         pixel_clk_q   <= 1'b0;
         frame_start_q <= 1'b0;
         hs_q          <= ~HS_POL;
         vs_q          <= ~VS_POL;
         blank_q       <= 1'b0;
      end else begin
         div_cnt_q     <= div_cnt_d;
         cycle_q       <= cycle_d;
         scanline_q    <= scanline_d;
         frame_count_q <= frame_count_d;
         pixel_clk_q   <= tick;
         frame_start_q <= wrap;
         hs_q          <= hs_d;
         vs_q          <= vs_d;
         blank_q       <= blank_d;
      end
   end

   assign pixel_clk   = pixel_clk_q;
   assign cycle       = cycle_q;
   assign scanline    = scanline_q;
   assign vga_hs      = hs_q;
   assign vga_vs      = vs_q;
   assign vga_blank   = blank_q;
   assign frame_start = frame_start_q;
   assign frame_count = frame_count_q;

`ifdef VGA_LINE_IRQ_EN
   logic irq_q, irq_set;

   // A line of V_TOTAL or more never matches scanline_d, so it can never fire.
   assign irq_set = tick && irq_line_en && (cycle_d == '0) && (scanline_d == irq_line);

   always_ff @(posedge CLK100MHz) begin
      if (rst) begin
         irq_q <= 1'b0;
      end else begin
         irq_q <= irq_set || (irq_q && !irq_ack);
      end
   end

   assign irq = irq_q;
`else
   logic unused_irq_in;

   assign unused_irq_in = ^{irq_line, irq_line_en, irq_ack};
   assign irq           = 1'b0;
`endif

endmodule
